// File: rtl/arb_pkg.sv
// Shared types for the L1 I/D to L2 request-port arbiter.
// Arbiter state encoding and requester identifiers.
package arb_pkg;

  typedef enum logic [1:0] {
    ARB_IDLE,
    ARB_SERVE_I,
    ARB_SERVE_D,
    ARB_RELEASE
  } arb_state_t;

  typedef enum logic {
    REQ_I,
    REQ_D
  } req_id_t;

  localparam logic [1:0] GNT_NONE = 2'b00;
  localparam logic [1:0] GNT_I    = 2'b01;
  localparam logic [1:0] GNT_D    = 2'b10;

endpackage

// File: rtl/l1_l2_arbiter_rr_pick.sv
// Combinational pick between the I-side and D-side requesters.
// Ties go to D under fixed priority, otherwise to the side not served last.
module arb_rr_pick
  import arb_pkg::*;
(
  input  logic    req_i,
  input  logic    req_d,
  input  req_id_t last_grant,
  input  logic    fixed_prio,
  output logic    grant_valid,
  output req_id_t grant_id
);

  always_comb begin
    grant_valid = req_i | req_d;
    grant_id    = REQ_I;
    unique case (1'b1)
      req_i && req_d:
        grant_id = (fixed_prio || last_grant == REQ_I) ? REQ_D : REQ_I;
      req_d && !req_i:
        grant_id = REQ_D;
      default:
        grant_id = REQ_I;
    endcase
  end

endmodule

// File: rtl/l1_l2_arbiter.sv
// Shares the single L2 request port between the L1 I-cache and D-cache.
// One transaction in flight; grant held until l2_resp, then one idle cycle.
module l1_l2_arbiter
  import arb_pkg::*;
#(
  parameter int ADDR_WIDTH = 16,
  parameter int LINE_WIDTH = 128,
  parameter int FIXED_PRIO = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  i_read,
  input  logic [ADDR_WIDTH-1:0] i_address,
  output logic [LINE_WIDTH-1:0] i_rdata,
  output logic                  i_resp,
  input  logic                  d_read,
  input  logic                  d_write,
  input  logic [ADDR_WIDTH-1:0] d_address,
  input  logic [LINE_WIDTH-1:0] d_wdata,
  output logic [LINE_WIDTH-1:0] d_rdata,
  output logic                  d_resp,
  output logic                  l2_read,
  output logic                  l2_write,
  output logic [ADDR_WIDTH-1:0] l2_address,
  output logic [LINE_WIDTH-1:0] l2_wdata,
  input  logic [LINE_WIDTH-1:0] l2_rdata,
  input  logic                  l2_resp,
  output logic [1:0]            arb_grant
);

  arb_state_t state, state_nx;
  req_id_t    last_grant;
  logic       grant_valid;
  req_id_t    grant_id;

  arb_rr_pick u_pick (
    .req_i       (i_read),
    .req_d       (d_read | d_write),
    .last_grant  (last_grant),
    .fixed_prio  (FIXED_PRIO != 0),
    .grant_valid (grant_valid),
    .grant_id    (grant_id)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= ARB_IDLE;
      last_grant <= REQ_I;
    end else begin
      state <= state_nx;
      if (state == ARB_IDLE && grant_valid)
        last_grant <= grant_id;
    end
  end

  always_comb begin
    state_nx = state;
    unique case (state)
      ARB_IDLE:
        if (grant_valid)
          state_nx = (grant_id == REQ_D) ? ARB_SERVE_D
                                         : ARB_SERVE_I;
      ARB_SERVE_I,
      ARB_SERVE_D:
        if (l2_resp)
          state_nx = ARB_RELEASE;
      ARB_RELEASE:
        state_nx = ARB_IDLE;
      default:
        state_nx = ARB_IDLE;
    endcase
  end

  // A simultaneous read and write from D is issued as a write.
  always_comb begin
    l2_read    = 1'b0;
    l2_write   = 1'b0;
    l2_address = '0;
    l2_wdata   = '0;
    i_rdata    = '0;
    i_resp     = 1'b0;
    d_rdata    = '0;
    d_resp     = 1'b0;
    arb_grant  = GNT_NONE;
    unique case (state)
      ARB_SERVE_I: begin
        l2_read    = i_read;
        l2_address = i_address;
        i_rdata    = l2_rdata;
        i_resp     = l2_resp;
        arb_grant  = GNT_I;
      end
      ARB_SERVE_D: begin
        l2_read    = d_read & ~d_write;
        l2_write   = d_write;
        l2_address = d_address;
        l2_wdata   = d_wdata;
        d_rdata    = l2_rdata;
        d_resp     = l2_resp;
        arb_grant  = GNT_D;
      end
      default: ;
    endcase
  end

endmodule
